// File: rtl/axi_lite_rr_arbiter.sv
// rtl/axi_lite_rr_arbiter.sv - round-robin transaction arbiter for a shared AXI4-Lite slave path
module axi_lite_rr_arbiter #(
   parameter int NUM_MASTER     = 2,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                          aclk,
   input  logic                          areset_n,
   input  logic [NUM_MASTER-1:0]         req_ar,
   input  logic [NUM_MASTER-1:0]         req_aw,
   input  logic                          sh_arvalid,
   input  logic                          sh_arready,
   input  logic                          sh_awvalid,
   input  logic                          sh_awready,
   input  logic                          sh_wvalid,
   input  logic                          sh_wready,
   input  logic                          sh_rvalid,
   input  logic                          sh_rready,
   input  logic                          sh_bvalid,
   input  logic                          sh_bready,
   output logic [NUM_MASTER-1:0]         grant,
   output logic [$clog2(NUM_MASTER)-1:0] grant_idx,
   output logic                          grant_valid,
   output logic                          grant_is_write,
   output logic                          timeout,
   output logic                          busy
);
   localparam int IDX_W = $clog2(NUM_MASTER);
   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_RESP, WR_ADDR, WR_RESP} state_t;

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       ptr_q, ptr_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   aw_done_q, aw_done_d;
   logic                   w_done_q, w_done_d;
   logic [NUM_MASTER-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
   logic                   grant_valid_q, grant_valid_d;
   logic                   grant_is_write_q, grant_is_write_d;
   logic                   timeout_q, timeout_d;
   logic                   busy_q, busy_d;

   logic                   ar_hs, aw_hs, w_hs, r_hs, b_hs;
   logic                   win_found, win_write, done;
   logic [IDX_W-1:0]       win_idx, scan_idx, nxt_ptr;

   assign ar_hs = sh_arvalid & sh_arready;
   assign aw_hs = sh_awvalid & sh_awready;
   assign w_hs  = sh_wvalid  & sh_wready;
   assign r_hs  = sh_rvalid  & sh_rready;
   assign b_hs  = sh_bvalid  & sh_bready;

   // Pointer after releasing the current owner: the master just past it.
   assign nxt_ptr = (grant_idx_q == IDX_W'(NUM_MASTER - 1)) ? '0 : grant_idx_q + IDX_W'(1);

   // Scan masters from the pointer, wrapping, and pick the first requester; reads beat writes.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      win_write = 1'b0;
      scan_idx  = '0;
      for (int k = 0; k < NUM_MASTER; k++) begin
         if (int'(ptr_q) + k >= NUM_MASTER)
            scan_idx = IDX_W'(int'(ptr_q) + k - NUM_MASTER);
         else
            scan_idx = IDX_W'(int'(ptr_q) + k);
         if (!win_found && (req_ar[scan_idx] || req_aw[scan_idx])) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
            win_write = !req_ar[scan_idx];
         end
      end
   end

   // Transaction tracking, release on completion or watchdog expiry, and next-state outputs.
   always_comb begin
      state_d          = state_q;
      ptr_d            = ptr_q;
      cnt_d            = cnt_q;
      aw_done_d        = aw_done_q;
      w_done_d         = w_done_q;
      grant_d          = grant_q;
      grant_idx_d      = grant_idx_q;
      grant_valid_d    = grant_valid_q;
      grant_is_write_d = grant_is_write_q;
      busy_d           = busy_q;
      timeout_d        = 1'b0;
      done             = 1'b0;
      case (state_q)
         IDLE: begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            if (win_found) begin
               state_d          = win_write ? WR_ADDR : RD_ADDR;
               grant_d          = NUM_MASTER'(1) << win_idx;
               grant_idx_d      = win_idx;
               grant_valid_d    = 1'b1;
               grant_is_write_d = win_write;
               busy_d           = 1'b1;
               cnt_d            = '0;
            end
         end
         RD_ADDR: if (ar_hs) state_d = RD_RESP;
         RD_RESP: if (r_hs) begin
            state_d = IDLE;
            done    = 1'b1;
         end
         WR_ADDR: begin
            if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
               state_d   = WR_RESP;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end else begin
               aw_done_d = aw_done_q | aw_hs;
               w_done_d  = w_done_q | w_hs;
            end
         end
         WR_RESP: if (b_hs) begin
            state_d = IDLE;
            done    = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (state_q != IDLE) begin
         if (done) begin
            grant_d       = '0;
            grant_valid_d = 1'b0;
            busy_d        = 1'b0;
            ptr_d         = nxt_ptr;
         end else if (TIMEOUT_CYCLES > 0 && cnt_q == CNT_LAST) begin
            state_d       = IDLE;
            timeout_d     = 1'b1;
            grant_d       = '0;
            grant_valid_d = 1'b0;
            busy_d        = 1'b0;
            ptr_d         = nxt_ptr;
            aw_done_d     = 1'b0;
            w_done_d      = 1'b0;
         end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge aclk) begin
      if (!areset_n) begin
         state_q          <= IDLE;
         ptr_q            <= '0;
         cnt_q            <= '0;
         aw_done_q        <= 1'b0;
         w_done_q         <= 1'b0;
         grant_q          <= '0;
         grant_idx_q      <= '0;
         grant_valid_q    <= 1'b0;
         grant_is_write_q <= 1'b0;
         timeout_q        <= 1'b0;
         busy_q           <= 1'b0;
      end else begin
         state_q          <= state_d;
         ptr_q            <= ptr_d;
         cnt_q            <= cnt_d;
         aw_done_q        <= aw_done_d;
         w_done_q         <= w_done_d;
         grant_q          <= grant_d;
         grant_idx_q      <= grant_idx_d;
         grant_valid_q    <= grant_valid_d;
         grant_is_write_q <= grant_is_write_d;
         timeout_q        <= timeout_d;
         busy_q           <= busy_d;
      end
   end

   assign grant          = grant_q;
   assign grant_idx      = grant_idx_q;
   assign grant_valid    = grant_valid_q;
   assign grant_is_write = grant_is_write_q;
   assign timeout        = timeout_q;
   assign busy           = busy_q;
endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// tb/tb_axi_lite_rr_arbiter.sv - self-checking bench for axi_lite_rr_arbiter
module tb_axi_lite_rr_arbiter;
   localparam int NM = 2;
   localparam int TO = 8;
   localparam logic [4:0] P_AR = 5'b00001;
   localparam logic [4:0] P_AW = 5'b00010;
   localparam logic [4:0] P_W  = 5'b00100;
   localparam logic [4:0] P_R  = 5'b01000;
   localparam logic [4:0] P_B  = 5'b10000;

   logic          aclk = 1'b0;
   logic          areset_n;
   logic [NM-1:0] req_ar, req_aw;
   logic          sh_arvalid, sh_arready, sh_awvalid, sh_awready, sh_wvalid, sh_wready;
   logic          sh_rvalid, sh_rready, sh_bvalid, sh_bready;
   logic [NM-1:0] grant;
   logic          grant_idx;
   logic          grant_valid, grant_is_write, timeout, busy;

   int n_checks = 0;
   int n_fail   = 0;

   // behavioural model: owner of the shared path (-1 = nobody) and transaction progress
   int m_owner = -1;
   int m_write = 0;
   int m_ptr   = 0;
   int m_held  = 0;
   int m_to    = 0;
   int m_aw = 0, m_w = 0, m_addr = 0, m_fin = 0, m_c = 0;
   bit chk_en  = 1'b0;

   axi_lite_rr_arbiter #(.NUM_MASTER(NM), .TIMEOUT_CYCLES(TO)) dut (
      .aclk(aclk), .areset_n(areset_n), .req_ar(req_ar), .req_aw(req_aw),
      .sh_arvalid(sh_arvalid), .sh_arready(sh_arready),
      .sh_awvalid(sh_awvalid), .sh_awready(sh_awready),
      .sh_wvalid(sh_wvalid), .sh_wready(sh_wready),
      .sh_rvalid(sh_rvalid), .sh_rready(sh_rready),
      .sh_bvalid(sh_bvalid), .sh_bready(sh_bready),
      .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid),
      .grant_is_write(grant_is_write), .timeout(timeout), .busy(busy)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model update: one transaction per owner, released on its final response or after TO held cycles.
   always @(posedge aclk) begin
      if (!areset_n) begin
         m_owner = -1; m_ptr = 0; m_to = 0; m_write = 0;
         chk_en  = 1'b1;
      end else if (m_owner < 0) begin
         m_to = 0;
         for (int k = 0; k < NM; k++) begin
            m_c = (m_ptr + k) % NM;
            if (m_owner < 0 && (req_ar[m_c] || req_aw[m_c])) begin
               m_owner = m_c;
               m_write = req_ar[m_c] ? 0 : 1;
            end
         end
         m_held = 0; m_aw = 0; m_w = 0; m_addr = 0;
      end else begin
         m_fin = 0;
         if (m_write == 0) begin
            if (m_addr == 0) m_addr = int'(sh_arvalid && sh_arready);
            else m_fin = int'(sh_rvalid && sh_rready);
         end else begin
            if (m_addr == 0) begin
               if (sh_awvalid && sh_awready) m_aw = 1;
               if (sh_wvalid && sh_wready) m_w = 1;
               m_addr = int'(m_aw == 1 && m_w == 1);
            end else m_fin = int'(sh_bvalid && sh_bready);
         end
         m_held++;
         if (m_fin == 1 || m_held == TO) begin
            m_to    = (m_fin == 1) ? 0 : 1;
            m_ptr   = (m_owner + 1) % NM;
            m_owner = -1;
         end else m_to = 0;
      end
   end

   // Compare DUT outputs against the model every cycle, away from the active edge.
   always @(negedge aclk) begin
      if (chk_en) begin
         check("grant", grant, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
         check("grant_valid", grant_valid, m_owner >= 0);
         check("busy", busy, m_owner >= 0);
         check("timeout", timeout, m_to);
         check("onehot", $countones(grant) <= 1, 1);
         if (m_owner >= 0) begin
            check("grant_idx", grant_idx, m_owner);
            check("grant_is_write", grant_is_write, m_write);
         end
      end
   end

   task automatic pulse(input logic [4:0] m);
      sh_arvalid = m[0]; sh_arready = m[0];
      sh_awvalid = m[1]; sh_awready = m[1];
      sh_wvalid  = m[2]; sh_wready  = m[2];
      sh_rvalid  = m[3]; sh_rready  = m[3];
      sh_bvalid  = m[4]; sh_bready  = m[4];
      @(negedge aclk);
      {sh_arvalid, sh_arready, sh_awvalid, sh_awready, sh_wvalid, sh_wready} = '0;
      {sh_rvalid, sh_rready, sh_bvalid, sh_bready} = '0;
   endtask

   task automatic wait_grant();
      int n = 0;
      while (!grant_valid && n < 30) begin
         @(negedge aclk);
         n++;
      end
      check("wait_grant", grant_valid, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int k;
      areset_n = 1'b0; req_ar = '0; req_aw = '0;
      {sh_arvalid, sh_arready, sh_awvalid, sh_awready, sh_wvalid, sh_wready} = '0;
      {sh_rvalid, sh_rready, sh_bvalid, sh_bready} = '0;
      repeat (3) @(negedge aclk);
      check("rst_grant", grant, 0);
      check("rst_idx", grant_idx, 0);
      check("rst_valid", grant_valid, 0);
      check("rst_write", grant_is_write, 0);
      check("rst_timeout", timeout, 0);
      check("rst_busy", busy, 0);
      areset_n = 1'b1;
      @(negedge aclk);
      check("idle_no_grant", grant_valid, 0);

      // 1: single read from master 0, AR 2 cycles after grant, R 3 cycles after AR
      req_ar = 2'b01;
      @(negedge aclk);
      check("t1_grant", grant, 2'b01);
      check("t1_read", grant_is_write, 0);
      @(negedge aclk);
      req_ar = 2'b00;
      pulse(P_AR);
      repeat (2) @(negedge aclk);
      check("t1_hold", grant, 2'b01);
      pulse(P_R);
      check("t1_release", grant, 2'b00);

      // 2: both masters read continuously; pointer is 1 so the order is 1,0,1,0
      req_ar = 2'b11;
      for (int t = 0; t < 4; t++) begin
         wait_grant();
         check("t2_order", grant_idx, (t % 2 == 0) ? 1 : 0);
         pulse(P_AR);
         pulse(P_R);
         if (t == 3) req_ar = 2'b00;
         check("t2_gap", grant_valid, 0);
      end

      // 3: master 1 write, W two cycles before AW, early B ignored
      req_aw = 2'b10;
      wait_grant();
      check("t3_grant", grant, 2'b10);
      check("t3_write", grant_is_write, 1);
      pulse(P_W);
      pulse(P_B);
      check("t3_b_early", grant_valid, 1);
      req_aw = 2'b00;
      pulse(P_AW);
      check("t3_wr_resp", grant_valid, 1);
      pulse(P_B);
      check("t3_release", grant_valid, 0);
      // AW and W in the same cycle
      req_aw = 2'b01;
      wait_grant();
      check("t3b_grant", grant, 2'b01);
      req_aw = 2'b00;
      pulse(P_AW | P_W);
      check("t3b_busy", busy, 1);
      pulse(P_B);
      check("t3b_release", grant_valid, 0);

      // 4: pointer to 0 via a master 1 read, then master 0 read+write with master 1 competing
      req_ar = 2'b10;
      wait_grant();
      check("t4_pre", grant, 2'b10);
      req_ar = 2'b00;
      pulse(P_AR);
      pulse(P_R);
      req_ar = 2'b01; req_aw = 2'b01;
      wait_grant();
      check("t4_rd_first", grant, 2'b01);
      check("t4_rd_kind", grant_is_write, 0);
      req_ar = 2'b10;
      pulse(P_AR);
      pulse(P_R);
      wait_grant();
      check("t4_m1_wins", grant, 2'b10);
      check("t4_m1_kind", grant_is_write, 0);
      req_ar = 2'b00;
      pulse(P_AR);
      pulse(P_R);
      wait_grant();
      check("t4_m0_write", grant, 2'b01);
      check("t4_wr_kind", grant_is_write, 1);
      req_aw = 2'b00;
      pulse(P_AW | P_W);
      pulse(P_B);
      // master 0 alone with both requests: read then its write
      req_ar = 2'b01; req_aw = 2'b01;
      wait_grant();
      check("t4b_read", grant_is_write, 0);
      req_ar = 2'b00;
      pulse(P_AR);
      pulse(P_R);
      wait_grant();
      check("t4b_write", grant, 2'b01);
      check("t4b_wkind", grant_is_write, 1);
      req_aw = 2'b00;
      pulse(P_AW | P_W);
      pulse(P_B);

      // 5: watchdog, arready never asserted; pointer is 1 so master 1 is granted first
      req_ar = 2'b11;
      wait_grant();
      check("t5_first", grant_idx, 1);
      k = 0;
      while (k < 20 && !timeout) begin
         @(negedge aclk);
         k++;
      end
      check("t5_latency", k, 8);
      check("t5_drop", grant_valid, 0);
      @(negedge aclk);
      check("t5_single_pulse", timeout, 0);
      check("t5_next", grant, 2'b01);
      req_ar = 2'b00;
      pulse(P_AR);
      pulse(P_R);

      // 6: reset during WR_RESP, then master 0 wins against master 1
      req_aw = 2'b01;
      wait_grant();
      req_aw = 2'b00;
      pulse(P_AW | P_W);
      check("t6_in_resp", busy, 1);
      areset_n = 1'b0;
      @(negedge aclk);
      check("t6_grant", grant, 0);
      check("t6_idx", grant_idx, 0);
      check("t6_valid", grant_valid, 0);
      check("t6_write", grant_is_write, 0);
      check("t6_timeout", timeout, 0);
      check("t6_busy", busy, 0);
      areset_n = 1'b1;
      req_ar = 2'b11;
      wait_grant();
      check("t6_m0", grant, 2'b01);
      req_ar = 2'b00;
      pulse(P_AR);
      pulse(P_R);
      repeat (3) @(negedge aclk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
